// File: rtl/mclk_switch_ctrl.sv
// mclk_switch_ctrl: master-clock source sequencer with an app-reset bracket around every select change.
// Optional MCLK_SWITCH_STATUS_EN adds a status word and a loss counter with a clear input.
module mclk_switch_ctrl #(
    parameter int QUAL_CYCLES     = 1024,
    parameter int RST_PRE_CYCLES  = 16,
    parameter int RST_POST_CYCLES = 64,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] cfg,
    input  logic       dtcclk_ok,
    input  logic       dtcclk_locked,
    input  logic       ethclk_ok,
    input  logic       ethclk_locked,
`ifdef MCLK_SWITCH_STATUS_EN
    input  logic        loss_clr,
    output logic [15:0] status,
`endif
    output logic [1:0] clksel,
    output logic       app_rst,
    output logic       switching
);
    typedef enum logic [1:0] {POST_RST = 2'd0, RUN = 2'd1, PRE_RST = 2'd2, SWITCH = 2'd3} state_t;

    localparam logic [CNT_W-1:0] QUAL = CNT_W'(QUAL_CYCLES);
    localparam logic [CNT_W-1:0] PRE  = CNT_W'(RST_PRE_CYCLES);
    localparam logic [CNT_W-1:0] POST = CNT_W'(RST_POST_CYCLES);

    logic [3:0]       meta, sync_q;
    logic             good_dtc, good_eth, qual_dtc, qual_eth;
    logic [CNT_W-1:0] qcnt_dtc, qcnt_eth, cnt, cnt_inc;
    logic [1:0]       force_sel, forced, prio, target, next_sel, sel_nx;
    logic             dtc_use, eth_use, hold;
    state_t           state, state_nx;
    logic             unused_cfg;

    assign unused_cfg = &{1'b0, cfg[7:6]};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta   <= '0;
            sync_q <= '0;
        end else begin
            {sync_q, meta} <= {meta, dtcclk_locked, dtcclk_ok, ethclk_locked, ethclk_ok};
        end
    end

    assign good_dtc = sync_q[3] & sync_q[2];
    assign good_eth = sync_q[1] & sync_q[0];

    // Qualification counters saturate at QUAL and clear as soon as the source goes bad.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            qcnt_dtc <= '0;
            qcnt_eth <= '0;
        end else begin
            qcnt_dtc <= !good_dtc ? '0 : (qcnt_dtc == QUAL) ? qcnt_dtc : qcnt_dtc + 1'b1;
            qcnt_eth <= !good_eth ? '0 : (qcnt_eth == QUAL) ? qcnt_eth : qcnt_eth + 1'b1;
        end
    end

    assign qual_dtc = (QUAL_CYCLES == 0) ? good_dtc : (qcnt_dtc == QUAL);
    assign qual_eth = (QUAL_CYCLES == 0) ? good_eth : (qcnt_eth == QUAL);

    always_comb begin
        force_sel = (cfg[5:4] == 2'b11) ? 2'b00 : cfg[5:4];
        forced    = (force_sel == 2'b01) ? (qual_dtc ? 2'b01 : 2'b00) :
                    (force_sel == 2'b10) ? (qual_eth ? 2'b10 : 2'b00) : 2'b00;
        dtc_use   = cfg[0] & qual_dtc;
        eth_use   = cfg[1] & qual_eth;
        hold      = !cfg[2] && ((clksel == 2'b01 && dtc_use) || (clksel == 2'b10 && eth_use));
        prio      = dtc_use ? 2'b01 : eth_use ? 2'b10 : 2'b00;
        target    = cfg[3] ? forced : hold ? clksel : prio;
    end

    assign cnt_inc = cnt + 1'b1;

    always_comb begin
        state_nx = state;
        sel_nx   = next_sel;
        case (state)
            POST_RST: if (cnt_inc >= POST) state_nx = RUN;
            RUN: if (target != clksel) begin
                state_nx = PRE_RST;
                sel_nx   = target;
            end
            PRE_RST:  if (cnt_inc >= PRE) state_nx = SWITCH;
            default:  state_nx = POST_RST;
        endcase
    end

    // app_rst is registered from the next state so it never glitches across PRE/SWITCH/POST.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= POST_RST;
            cnt       <= '0;
            next_sel  <= 2'b00;
            clksel    <= 2'b00;
            app_rst   <= 1'b1;
            switching <= 1'b1;
        end else begin
            state     <= state_nx;
            cnt       <= (state_nx == state) ? cnt_inc : '0;
            next_sel  <= sel_nx;
            clksel    <= (state == SWITCH) ? next_sel : clksel;
            app_rst   <= state_nx != RUN;
            switching <= state_nx != RUN;
        end
    end

`ifdef MCLK_SWITCH_STATUS_EN
    logic [7:0] loss_cnt;
    logic       loss;

    assign loss = (state == RUN) && ((clksel == 2'b01 && !qual_dtc) || (clksel == 2'b10 && !qual_eth));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) loss_cnt <= '0;
        else loss_cnt <= loss_clr ? 8'd0 : (loss && loss_cnt != 8'hff) ? loss_cnt + 1'b1 : loss_cnt;
    end

    assign status = {loss_cnt, 2'b00, qual_eth, qual_dtc, state, clksel};
`endif
endmodule

// File: tb/tb_mclk_switch_ctrl.sv
// tb_mclk_switch_ctrl: directed table for the switch scenarios plus randomized stimulus
// checked every cycle against a cycle-level behavioural model of the sequencer.
module tb_mclk_switch_ctrl;
    localparam int QC = 1024, PRE = 16, POST = 64;

    logic       clk = 0, rstn = 0;
    logic [7:0] cfg = 0;
    logic       dok = 0, dlk = 0, eok = 0, elk = 0;
    logic [1:0] clksel;
    logic       app_rst, switching;
    logic       loss_clr = 0;
`ifdef MCLK_SWITCH_STATUS_EN
    logic [15:0] status;
`endif
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    mclk_switch_ctrl dut (
        .clk(clk), .rstn(rstn), .cfg(cfg),
        .dtcclk_ok(dok), .dtcclk_locked(dlk), .ethclk_ok(eok), .ethclk_locked(elk),
`ifdef MCLK_SWITCH_STATUS_EN
        .loss_clr(loss_clr), .status(status),
`endif
        .clksel(clksel), .app_rst(app_rst), .switching(switching)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: good streak lengths, phase with a remaining-cycle countdown.
    int m_phase, m_left, m_sel, m_nsel, m_sd, m_se, m_loss, m_t;
    bit m_d0, m_d1, m_e0, m_e1, m_qd, m_qe;

    function automatic int tgt(input logic [7:0] c, input bit qd, input bit qe, input int cur);
        bit de = c[0] && qd;
        bit ee = c[1] && qe;
        int fs = int'(c[5:4]);
        if (c[3]) return (fs == 1) ? (qd ? 1 : 0) : (fs == 2) ? (qe ? 2 : 0) : 0;
        if (!c[2] && ((cur == 1 && de) || (cur == 2 && ee))) return cur;
        return de ? 1 : ee ? 2 : 0;
    endfunction

    assign m_qd = m_sd >= QC;
    assign m_qe = m_se >= QC;
    assign m_t  = tgt(cfg, m_qd, m_qe, m_sel);

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_phase <= 0; m_left <= POST; m_sel <= 0; m_nsel <= 0;
            m_sd <= 0; m_se <= 0; m_loss <= 0;
            m_d0 <= 0; m_d1 <= 0; m_e0 <= 0; m_e1 <= 0;
        end else begin
            if (loss_clr) m_loss <= 0;
            else if (m_phase == 1 && ((m_sel == 1 && !m_qd) || (m_sel == 2 && !m_qe)) && m_loss < 255)
                m_loss <= m_loss + 1;
            case (m_phase)
                0: begin m_left <= m_left - 1; if (m_left == 1) m_phase <= 1; end
                1: if (m_t != m_sel) begin m_nsel <= m_t; m_phase <= 2; m_left <= PRE; end
                2: begin m_left <= m_left - 1; if (m_left == 1) m_phase <= 3; end
                default: begin m_sel <= m_nsel; m_phase <= 0; m_left <= POST; end
            endcase
            m_sd <= m_d1 ? m_sd + 1 : 0;
            m_se <= m_e1 ? m_se + 1 : 0;
            m_d1 <= m_d0; m_d0 <= dok & dlk;
            m_e1 <= m_e0; m_e0 <= eok & elk;
        end
    end

    always @(negedge clk) begin
        chk("model_clksel", 32'(clksel), 32'(m_sel));
        chk("model_app_rst", 32'(app_rst), 32'(m_phase != 1));
        chk("model_switching", 32'(switching), 32'(m_phase != 1));
`ifdef MCLK_SWITCH_STATUS_EN
        chk("model_status", 32'(status), 32'({8'(m_loss), 2'b00, m_qe, m_qd, 2'(m_phase), 2'(m_sel)}));
`endif
    end

    typedef struct {
        logic [7:0] cfg;
        bit         dok, dlk, eok, elk;
        int         wait_n;
        int         sel;
        bit         rst;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic [7:0] c, input bit a, input bit b, input bit d, input bit e,
                               input int n, input int s, input bit r);
        v.cfg = c; v.dok = a; v.dlk = b; v.eok = d; v.elk = e;
        v.wait_n = n; v.sel = s; v.rst = r;
    endfunction

    initial begin
        tbl.push_back(v(8'h00, 0, 0, 0, 0, 63, 0, 1));
        tbl.push_back(v(8'h00, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(v(8'h01, 1, 1, 0, 0, 1026, 0, 0));
        tbl.push_back(v(8'h01, 1, 1, 0, 0, 1, 0, 1));
        tbl.push_back(v(8'h01, 1, 1, 0, 0, 16, 0, 1));
        tbl.push_back(v(8'h01, 1, 1, 0, 0, 1, 1, 1));
        tbl.push_back(v(8'h01, 1, 1, 0, 0, 63, 1, 1));
        tbl.push_back(v(8'h01, 1, 1, 0, 0, 1, 1, 0));
        tbl.push_back(v(8'h03, 1, 1, 1, 1, 1100, 1, 0));
        tbl.push_back(v(8'h03, 1, 0, 1, 1, 1, 1, 0));
        tbl.push_back(v(8'h03, 1, 1, 1, 1, 2, 1, 0));
        tbl.push_back(v(8'h03, 1, 1, 1, 1, 1, 1, 1));
        tbl.push_back(v(8'h03, 1, 1, 1, 1, 16, 1, 1));
        tbl.push_back(v(8'h03, 1, 1, 1, 1, 1, 2, 1));
        tbl.push_back(v(8'h03, 1, 1, 1, 1, 63, 2, 1));
        tbl.push_back(v(8'h03, 1, 1, 1, 1, 1, 2, 0));
        tbl.push_back(v(8'h03, 1, 1, 1, 1, 1100, 2, 0));
        tbl.push_back(v(8'h07, 1, 1, 1, 1, 1, 2, 1));
        tbl.push_back(v(8'h07, 1, 1, 1, 1, 16, 2, 1));
        tbl.push_back(v(8'h07, 1, 1, 1, 1, 1, 1, 1));
        tbl.push_back(v(8'h07, 1, 1, 1, 1, 64, 1, 0));
        tbl.push_back(v(8'h38, 1, 1, 0, 1, 1, 1, 1));
        tbl.push_back(v(8'h38, 1, 1, 0, 1, 17, 0, 1));
        tbl.push_back(v(8'h38, 1, 1, 0, 1, 64, 0, 0));
        tbl.push_back(v(8'h28, 1, 1, 0, 1, 5, 0, 0));
        tbl.push_back(v(8'h28, 1, 1, 1, 1, 1026, 0, 0));
        tbl.push_back(v(8'h28, 1, 1, 1, 1, 1, 0, 1));
        tbl.push_back(v(8'h28, 1, 1, 1, 1, 16, 0, 1));
        tbl.push_back(v(8'h28, 1, 1, 1, 1, 1, 2, 1));
        tbl.push_back(v(8'h28, 1, 1, 1, 1, 64, 2, 0));

        repeat (2) @(negedge clk);
        chk("reset_clksel", 32'(clksel), 0);
        chk("reset_app_rst", 32'(app_rst), 1);
        chk("reset_switching", 32'(switching), 1);
        rstn = 1;
        for (int i = 0; i < tbl.size(); i++) begin
            cfg = tbl[i].cfg; dok = tbl[i].dok; dlk = tbl[i].dlk; eok = tbl[i].eok; elk = tbl[i].elk;
            repeat (tbl[i].wait_n) @(negedge clk);
            chk($sformatf("row%0d_clksel", i), 32'(clksel), 32'(tbl[i].sel));
            chk($sformatf("row%0d_app_rst", i), 32'(app_rst), 32'(tbl[i].rst));
            chk($sformatf("row%0d_switching", i), 32'(switching), 32'(tbl[i].rst));
        end

        // Reset asserted in the middle of PRE_RST must take effect without a clock.
        cfg = 8'h07;
        repeat (5) @(negedge clk);
        chk("pre_clksel", 32'(clksel), 2);
        chk("pre_app_rst", 32'(app_rst), 1);
        rstn = 0;
        #1;
        chk("async_clksel", 32'(clksel), 0);
        chk("async_app_rst", 32'(app_rst), 1);
        chk("async_switching", 32'(switching), 1);
        @(negedge clk);
        rstn = 1;

        for (int i = 0; i < 26; i++) begin
            int n;
            cfg = 8'($urandom);
            if ($urandom_range(0, 2) != 0) cfg[3] = 1'b0;
            dok = $urandom_range(0, 3) != 0; dlk = $urandom_range(0, 3) != 0;
            eok = $urandom_range(0, 3) != 0; elk = $urandom_range(0, 3) != 0;
            n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(20, 2200);
            loss_clr = $urandom_range(0, 5) == 0;
            @(negedge clk);
            loss_clr = 1'b0;
            repeat (n) @(negedge clk);
            if (i == 13) begin
                rstn = 0;
                repeat (3) @(negedge clk);
                rstn = 1;
            end
        end
        loss_clr = 1'b1;
        @(negedge clk);
        loss_clr = 1'b0;
`ifdef MCLK_SWITCH_STATUS_EN
        chk("loss_clr_status", 32'(status[15:8]), 0);
`endif
        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mclk_switch_ctrl.md
Name: mclk_switch_ctrl

Overview:
- Sequencer for the master-clock source mux (local clk0, DTC recovered clock, Ethernet-derived clk40e).
- Synchronises and qualifies the lock/ok status of each external source, picks the target source by priority and configuration, and drives the two-level mux select.
- Wraps every switch in an application-reset bracket: reset before the select changes, and held through a settle window after it.
- Runs on the always-present local clock.

Parameters:
- QUAL_CYCLES, 1024: consecutive cycles a source must be good before it is qualified.
- RST_PRE_CYCLES, 16: cycles app_rst is held before the select changes.
- RST_POST_CYCLES, 64: cycles app_rst is held after the select changes.
- CNT_W, 16: width of the qualification and reset counters; must hold the largest cycle parameter.

Ports:
- clk  input  1  local free-running clock.
- rstn  input  1  asynchronous active-low reset.
- cfg  input  8  [0] dtc_en, [1] eth_en, [2] auto_revert, [3] force, [5:4] force_sel, [7:6] reserved.
- dtcclk_ok  input  1  DTC clock present; asynchronous.
- dtcclk_locked  input  1  DTC MMCM locked; asynchronous.
- ethclk_ok  input  1  Ethernet clock present; asynchronous.
- ethclk_locked  input  1  Ethernet MMCM locked; asynchronous.
- clksel  output  2  00 local, 01 DTC, 10 ETH; 11 is never driven.
- app_rst  output  1  application reset, active-high.
- switching  output  1  high in every state except RUN.

Behaviour:
- Reset is asynchronous and active-low, sampled on clk. One clock, no other domains.
- All four status inputs pass through 2-flop synchronisers before use.
- good_dtc = ok & locked, both synchronised. good_eth is formed the same way from the ETH inputs.
- Qualification counters, one per source:
  - Increment while good, saturating at QUAL_CYCLES.
  - Clear in the same cycle good drops.
  - qual_x = (count == QUAL_CYCLES). With QUAL_CYCLES = 0, qual_x = good_x.
- Target computation:
  - force = 1: target = force_sel (11 maps to 00). A forced DTC/ETH target also needs qual_x, otherwise target = local.
  - force = 0: target = DTC if dtc_en & qual_dtc; else ETH if eth_en & qual_eth; else local.
  - auto_revert = 0 with force = 0: while on a qualified, enabled source, target stays on the current source even if a higher-priority source qualifies.
  - A source that is lost or disabled always forces re-evaluation.
- States:
  - POST_RST (entered on reset): app_rst = 1; counts RST_POST_CYCLES cycles, then goes to RUN.
  - RUN: app_rst = 0. If target != clksel, latch target into next_sel and go to PRE_RST.
  - PRE_RST: app_rst = 1; counts RST_PRE_CYCLES cycles, then goes to SWITCH.
  - SWITCH: one cycle; clksel <= next_sel; goes to POST_RST.
- Reset values: clksel = 00, app_rst = 1, switching = 1, state = POST_RST, counters = 0.
- Latency:
  - Source good to qualified: 2 sync + QUAL_CYCLES cycles.
  - Change decision in RUN to clksel update: RST_PRE_CYCLES + 1 cycles.
  - app_rst is contiguous across PRE_RST, SWITCH and POST_RST, with no glitch.
- Loss of the active external source in RUN: qual clears, the target recomputes, and the normal switch sequence starts the next cycle. There is no immediate select change.
- Cfg or status changes during PRE_RST/SWITCH/POST_RST do not alter next_sel. They are re-evaluated on return to RUN, which may immediately start another sequence.
- Counter compare is against the parameter itself, never parameter-1.
- Asserting rstn low mid-sequence returns everything to the reset values at once.

Optional Feature:
- Macro MCLK_SWITCH_STATUS_EN.
- When defined, adds two ports:
  - status  output  16: [1:0] clksel, [3:2] state encoding, [4] qual_dtc, [5] qual_eth, [7:6] reserved 0, [15:8] loss_cnt.
  - loss_clr  input  1: synchronous clear of loss_cnt.
- loss_cnt is a saturating 8-bit count of RUN-state losses of the active external source; it stops at 255.
- loss_clr and a loss in the same cycle: the clear wins.
- When not defined: no extra ports and no loss counter.

Test Plan:
- Reset release with all sources bad -> app_rst stays high exactly 64 cycles, then low; clksel = 00; switching = 0.
- cfg = 0x01, DTC ok+locked at cycle 100 -> after 2 + 1024 cycles app_rst rises; 16 cycles later clksel = 01; app_rst falls 64 cycles after that.
- While on DTC, drop dtcclk_locked for 1 cycle, cfg = 0x03, ETH qualified -> sequence to clksel = 10 with full 16/1/64 reset bracket.
- cfg = 0x03, auto_revert = 0, on ETH, DTC requalifies -> clksel stays 10. Set cfg = 0x07 -> switch to 01.
- cfg = 0x38 (force, sel = 11) -> clksel = 00. cfg = 0x28 with ETH unqualified -> stays 00; ETH qualifies -> switch to 10.
- Assert rstn low during PRE_RST -> clksel = 00, app_rst = 1 immediately. With MCLK_SWITCH_STATUS_EN, two losses -> status[15:8] = 2; loss_clr -> 0.
